// File: rtl/tetris_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// enum_type -- shared types and helpers for the Tetris controller slice.
//
// Contents:
//   state_type      : core states and controller commands share one encoding
//   BTN_*           : bit positions inside the 7-bit btn bus
//   levelFromScore  : BCD score -> difficulty level (0..9)
//   gravPeriod      : level -> gravity period in clk cycles
// ---------------------------------------------------------------------------
package enum_type;

    typedef enum logic [3:0] {
        NONE       = 4'd0,
        INIT       = 4'd1,
        GEN        = 4'd2,
        WAIT       = 4'd3,
        BAR        = 4'd4,
        END        = 4'd5,
        HOLD       = 4'd6,
        DROP       = 4'd7,
        ROTATE     = 4'd8,
        ROTATE_REV = 4'd9,
        LEFT       = 4'd10,
        RIGHT      = 4'd11,
        DOWN       = 4'd12
    } state_type;

    localparam int BTN_LEFT       = 0;
    localparam int BTN_RIGHT      = 1;
    localparam int BTN_ROTATE     = 2;
    localparam int BTN_ROTATE_REV = 3;
    localparam int BTN_DOWN       = 4;
    localparam int BTN_DROP       = 5;
    localparam int BTN_HOLD       = 6;
    localparam int BTN_W          = 7;

    // Any non-zero hundreds/thousands digit pins the level at its maximum.
    function automatic logic [3:0] levelFromScore(input logic [15:0] score);
        return (score[15:8] != 8'd0) ? 4'd9 : score[7:4];
    endfunction

    function automatic logic [31:0] gravPeriod(input logic [3:0] level,
                                               input int base,
                                               input int step);
        return 32'(base - int'(level) * step);
    endfunction

endpackage

// File: rtl/tetris_cmd_fifo.sv
// ---------------------------------------------------------------------------
// tetris_cmd_fifo -- small command FIFO carrying state_type payloads.
//
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   flush_i         : synchronous clear of all entries
//   push_i, data_i  : write request and command (accepted when not full or
//                     when a pop happens in the same cycle)
//   pop_i           : read request (ignored when empty)
//   data_o          : head entry, valid while empty_o is low
//   full_o, empty_o : occupancy flags
// ---------------------------------------------------------------------------
module tetris_cmd_fifo
    import enum_type::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      flush_i,
    input  logic      push_i,
    input  state_type data_i,
    input  logic      pop_i,
    output state_type data_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    state_type      mem_q [DEPTH];
    logic [AW-1:0]  wrPtr_q;
    logic [AW-1:0]  rdPtr_q;
    logic [AW:0]    count_q;
    logic           doPush;
    logic           doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rdPtr_q];

    // A pop frees the slot the simultaneous push needs, so a full FIFO still
    // accepts a write in a pop cycle.
    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (doPush && !flush_i) mem_q[wrPtr_q] <= data_i;
    end

endmodule

// File: rtl/tetris_ctrl.sv
// ---------------------------------------------------------------------------
// tetris_ctrl -- turns button edges, gravity and garbage-row offers into
// single-cycle commands for the Tetris game core.
//
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   btn[6:0]               : {hold, drop, down, rotate_rev, rotate, right, left}
//   core_state             : current core state
//   score[15:0]            : BCD score, selects the gravity level
//   bar_valid, bar_mask_in : garbage-row offer
//   bar_ready              : garbage latch empty
//   ctrl                   : registered command, NONE when idle
//   bar_mask               : garbage row presented to the core
//   overflow               : one-cycle pulse when a button edge is dropped
//
// Build option: define TETRIS_AUTOREPEAT_EN to add DAS/ARR auto-repeat on
// left, right and down. Without it only edges create commands.
// ---------------------------------------------------------------------------
module tetris_ctrl
    import enum_type::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int GRAVITY_BASE = 50_000_000,
    parameter int GRAVITY_STEP = 5_000_000,
    parameter int DAS_CYCLES   = 20_000_000,
    parameter int ARR_CYCLES   = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] btn,
    input  state_type  core_state,
    input  logic [15:0] score,
    input  logic       bar_valid,
    input  logic [9:0] bar_mask_in,
    output logic       bar_ready,
    output state_type  ctrl,
    output logic [9:0] bar_mask,
    output logic       overflow
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        DAS_CYCLES < 1 || ARR_CYCLES < 1 ||
        GRAVITY_BASE <= 9 * GRAVITY_STEP) begin : gBadParams
        $error("tetris_ctrl: illegal parameter set");
    end

    logic [BTN_W-1:0] btnPrev_q, flags_q, flags_d;
    logic [BTN_W-1:0] edges, cand, pushOneHot, rptSet;
    state_type        coreState_q, ctrl_q, ctrl_d, pushCmd, fifoHead;
    logic             fifoFull, fifoEmpty, fifoPush, fifoPop;
    logic             idle, canIssue, fullEff, overflow_q, overflow_d;
    logic [31:0]      gravCnt_q, gravCnt_d, period;
    logic             gravPend_q, gravPend_d, gravExpire;
    logic [9:0]       barMask_q, barMask_d;
    logic             barPend_q, barPend_d, barIssued_q, barIssued_d;

    assign ctrl      = ctrl_q;
    assign overflow  = overflow_q;
    assign bar_mask  = barMask_q;
    assign bar_ready = !barPend_q;

    tetris_cmd_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (idle),
        .push_i  (fifoPush),
        .data_i  (pushCmd),
        .pop_i   (fifoPop),
        .data_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

`ifdef TETRIS_AUTOREPEAT_EN
    localparam int RPT_N = 3;
    localparam int RPT_BIT [RPT_N] = '{BTN_LEFT, BTN_RIGHT, BTN_DOWN};

    logic [31:0]      rptCnt_q [RPT_N];
    logic [RPT_N-1:0] rptArmed_q;
    logic [RPT_N-1:0] rptHeld, rptFire;

    // First repeat after DAS_CYCLES of continuous hold, then every ARR_CYCLES.
    always_comb begin
        rptSet  = '0;
        rptHeld = '0;
        rptFire = '0;
        for (int i = 0; i < RPT_N; i++) begin
            rptHeld[i] = btn[RPT_BIT[i]] && btnPrev_q[RPT_BIT[i]];
            rptFire[i] = rptHeld[i] &&
                ((!rptArmed_q[i] && rptCnt_q[i] == 32'(DAS_CYCLES - 1)) ||
                 ( rptArmed_q[i] && rptCnt_q[i] == 32'(ARR_CYCLES - 1)));
            rptSet[RPT_BIT[i]] = rptFire[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RPT_N; i++) rptCnt_q[i] <= '0;
            rptArmed_q <= '0;
        end else begin
            for (int i = 0; i < RPT_N; i++) begin
                if (!rptHeld[i]) begin
                    rptCnt_q[i]   <= '0;
                    rptArmed_q[i] <= 1'b0;
                end else if (rptFire[i]) begin
                    rptCnt_q[i]   <= '0;
                    rptArmed_q[i] <= 1'b1;
                end else begin
                    rptCnt_q[i] <= rptCnt_q[i] + 32'd1;
                end
            end
        end
    end
`else
    assign rptSet = '0;
`endif

    assign period = gravPeriod(levelFromScore(score), GRAVITY_BASE, GRAVITY_STEP);

    always_comb begin
        edges      = (btn & ~btnPrev_q) | rptSet;
        idle       = (coreState_q == INIT) || (coreState_q == END);
        canIssue   = !idle && (coreState_q == WAIT) && (ctrl_q == NONE);
        fifoPop    = canIssue && !fifoEmpty;
        fullEff    = fifoFull && !fifoPop;

        // Command selection: queued buttons first, then gravity, then garbage.
        // While idle a button only nudges the core with DOWN.
        ctrl_d = NONE;
        if (idle) begin
            if (|edges) ctrl_d = DOWN;
        end else if (canIssue) begin
            if (!fifoEmpty)                     ctrl_d = fifoHead;
            else if (gravPend_q)                ctrl_d = DOWN;
            else if (barPend_q && !barIssued_q) ctrl_d = BAR;
        end

        // New edges join the pending flags so a lone press reaches the FIFO
        // in the same cycle. With no room, fresh edges are dropped.
        cand       = '0;
        pushOneHot = '0;
        pushCmd    = NONE;
        overflow_d = 1'b0;
        flags_d    = '0;
        if (!idle) begin
            cand       = fullEff ? flags_q : (flags_q | edges);
            overflow_d = fullEff && (|edges);
            if (!fullEff) begin
                if      (cand[BTN_HOLD])       begin pushOneHot[BTN_HOLD]       = 1'b1; pushCmd = HOLD;       end
                else if (cand[BTN_DROP])       begin pushOneHot[BTN_DROP]       = 1'b1; pushCmd = DROP;       end
                else if (cand[BTN_ROTATE])     begin pushOneHot[BTN_ROTATE]     = 1'b1; pushCmd = ROTATE;     end
                else if (cand[BTN_ROTATE_REV]) begin pushOneHot[BTN_ROTATE_REV] = 1'b1; pushCmd = ROTATE_REV; end
                else if (cand[BTN_LEFT])       begin pushOneHot[BTN_LEFT]       = 1'b1; pushCmd = LEFT;       end
                else if (cand[BTN_RIGHT])      begin pushOneHot[BTN_RIGHT]      = 1'b1; pushCmd = RIGHT;      end
                else if (cand[BTN_DOWN])       begin pushOneHot[BTN_DOWN]       = 1'b1; pushCmd = DOWN;       end
            end
            flags_d = cand & ~pushOneHot;
        end
        fifoPush = |pushOneHot;

        // Gravity: >= rather than == keeps the counter bounded when a level-up
        // shortens the period below the current count.
        gravExpire = 1'b0;
        gravCnt_d  = gravCnt_q;
        if (coreState_q == GEN) begin
            gravCnt_d = '0;
        end else if (!idle) begin
            if (gravCnt_q >= period - 32'd1) begin
                gravCnt_d  = '0;
                gravExpire = 1'b1;
            end else begin
                gravCnt_d = gravCnt_q + 32'd1;
            end
        end

        gravPend_d = gravPend_q;
        if (idle) begin
            gravPend_d = 1'b0;
        end else begin
            if (ctrl_d == DOWN || ctrl_d == DROP) gravPend_d = 1'b0;
            if (gravExpire)                       gravPend_d = 1'b1;
        end

        // Garbage row: latched until the core has spent a cycle in BAR.
        barPend_d   = barPend_q;
        barIssued_d = barIssued_q;
        barMask_d   = barMask_q;
        if (bar_valid && !barPend_q && bar_mask_in != 10'd0) begin
            barPend_d   = 1'b1;
            barIssued_d = 1'b0;
            barMask_d   = bar_mask_in;
        end
        if (ctrl_d == BAR) barIssued_d = 1'b1;
        if (barIssued_q && coreState_q == BAR) begin
            barPend_d   = 1'b0;
            barIssued_d = 1'b0;
            barMask_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btnPrev_q   <= '0;
            flags_q     <= '0;
            coreState_q <= INIT;
            ctrl_q      <= NONE;
            overflow_q  <= 1'b0;
            gravCnt_q   <= '0;
            gravPend_q  <= 1'b0;
            barMask_q   <= '0;
            barPend_q   <= 1'b0;
            barIssued_q <= 1'b0;
        end else begin
            btnPrev_q   <= btn;
            flags_q     <= flags_d;
            coreState_q <= core_state;
            ctrl_q      <= ctrl_d;
            overflow_q  <= overflow_d;
            gravCnt_q   <= gravCnt_d;
            gravPend_q  <= gravPend_d;
            barMask_q   <= barMask_d;
            barPend_q   <= barPend_d;
            barIssued_q <= barIssued_d;
        end
    end

endmodule
